ld_cell_steer_mon: RTL

//  Parametrised successor to the two-cell steer-enable block: monitors NUM_CELLS load cells.

---
 rtl/ld_cell_steer_mon.sv | 133 +++++++++++++
 1 files changed

// File: rtl/ld_cell_steer_mon.sv
// Load-cell steer monitor: group sums, L-R diff, hysteresis/dwell FSM.
// Optional build macro LD_FAST_SIM_EN shortens the dwell to TMR_FAST.
module ld_cell_steer_mon #(
   parameter int          NUM_CELLS    = 4,
   parameter logic [11:0] MIN_RIDER_WT = 12'h200,
   parameter logic [11:0] WT_HYST      = 12'h040,
   parameter int          DIFF_SHIFT   = 2,
   parameter logic [25:0] TMR_MAX      = 26'd67_108_863,
   parameter logic [14:0] TMR_FAST     = 15'd32_767,
   localparam int         GW = 12 + $clog2(NUM_CELLS/2),
   localparam int         SW = GW + 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [12*NUM_CELLS-1:0] ld,
   input  logic                    ld_vld,
   output logic [SW-1:0]           sum_wt,
   output logic [SW-1:0]           ld_cell_diff,
   output logic                    rider_off,
   output logic                    en_steer
);

`ifdef LD_FAST_SIM_EN
   localparam int          TW    = 15;
   localparam logic [TW-1:0] DWELL = TMR_FAST;
`else
   localparam int          TW    = $clog2(TMR_MAX + 1);
   localparam logic [TW-1:0] DWELL = TW'(TMR_MAX);
`endif

   localparam logic [SW-1:0] ON_LVL  = SW'(MIN_RIDER_WT) + SW'(WT_HYST);
   localparam logic [SW-1:0] OFF_LVL = SW'(MIN_RIDER_WT) - SW'(WT_HYST);

   localparam logic [1:0] S_OFF   = 2'd0;
   localparam logic [1:0] S_WAIT  = 2'd1;
   localparam logic [1:0] S_STEER = 2'd2;

   logic [GW-1:0] lsum;
   logic [GW-1:0] rsum;
   logic [SW-1:0] abs_diff;
   logic [SW-1:0] quarter;
   logic          on_thr;
   logic          off_thr;
   logic          small_d;
   logic          large_d;
   logic [1:0]    state;
   logic [1:0]    nxt_state;
   logic [TW-1:0] tmr;
   logic [TW-1:0] nxt_tmr;

   // Left/right group sums of the current cell readings
   always_comb begin
      lsum = '0;
      rsum = '0;
      for (int k = 0; k < NUM_CELLS/2; k++)
         lsum = lsum + GW'(ld[12*k +: 12]);
      for (int k = NUM_CELLS/2; k < NUM_CELLS; k++)
         rsum = rsum + GW'(ld[12*k +: 12]);
   end

   // Capture total and signed difference on each fresh reading set
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_wt       <= '0;
         ld_cell_diff <= '0;
      end else if (ld_vld) begin
         sum_wt       <= SW'(lsum) + SW'(rsum);
         ld_cell_diff <= SW'(lsum) - SW'(rsum);
      end
   end

   // Threshold compares on the registered values
   always_comb begin
      abs_diff = ld_cell_diff[SW-1] ? -ld_cell_diff : ld_cell_diff;
      quarter  = sum_wt >> DIFF_SHIFT;
      on_thr   = (sum_wt >= ON_LVL);
      off_thr  = (sum_wt < OFF_LVL);
      small_d  = (abs_diff < quarter);
      large_d  = (abs_diff > (sum_wt - quarter));
   end

   // Next-state and dwell-timer logic; off_thr dominates
   always_comb begin
      nxt_state = state;
      nxt_tmr   = tmr;
      case (state)
         S_OFF: begin
            if (on_thr) begin
               nxt_state = S_WAIT;
               nxt_tmr   = '0;
            end
         end
         S_WAIT: begin
            if (off_thr)
               nxt_state = S_OFF;
            else if (!small_d)
               nxt_tmr = '0;
            else if (tmr >= DWELL)
               nxt_state = S_STEER;
            else
               nxt_tmr = tmr + TW'(1);
         end
         S_STEER: begin
            if (off_thr)
               nxt_state = S_OFF;
            else if (large_d) begin
               nxt_state = S_WAIT;
               nxt_tmr   = '0;
            end
         end
         default: begin
            nxt_state = S_OFF;
            nxt_tmr   = '0;
         end
      endcase
   end

   // State, timer and flags decoded from the next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_OFF;
         tmr       <= '0;
         rider_off <= 1'b1;
         en_steer  <= 1'b0;
      end else begin
         state     <= nxt_state;
         tmr       <= nxt_tmr;
         rider_off <= (nxt_state == S_OFF);
         en_steer  <= (nxt_state == S_STEER);
      end
   end

endmodule
